// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: opcodes, access-size
// encodings, FSM states and the funct3 legality rule.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    else          ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the LSU: store byte enables and replicated write data,
// and right-shifted, sign/zero-extended load data.
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  import lsu_pkg::*;

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    shifted   = load_word >> {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        be    = '1;
        wdata = store_data;
      end
      default: ;
    endcase

    case (funct3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LW:      load_data = shifted;
      LBU:     load_data = {24'b0, shifted[7:0]};
      LHU:     load_data = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs a req/gnt/rvalid bus transaction for loads and stores and
// stalls the core until it completes. LSU_MISALIGN_TRAP_EN selects trap vs. force-align.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [6:0]  opcode_reg,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  import lsu_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  logic        mem_op;
  logic        is_store;
  logic [31:0] addr_in;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_data;

  assign is_store = (opcode_reg == OP_STORE);
  assign mem_op   = valid_in && ((opcode_reg == OP_LOAD) || is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_in;
  assign misal_in = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                    ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  assign addr_in  = ALUResult;
`else
  // Misaligned accesses are silently rounded down to the access size.
  always_comb begin
    addr_in = ALUResult;
    if (funct3[1:0] == 2'b01)      addr_in[0]   = 1'b0;
    else if (funct3[1:0] == 2'b10) addr_in[1:0] = 2'b00;
  end
`endif

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .load_word  (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    data_d     = data_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d     = addr_in;
          funct3_d   = funct3;
          data_d     = store_data;
          we_d       = is_store;
          cnt_d      = '0;
          rd_data_d  = '0;
          bus_err_d  = 1'b0;
          misalign_d = 1'b0;
          if (!f3_legal(is_store, funct3)) begin
            state_d   = DONE;
            bus_err_d = 1'b1;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misal_in) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end
`endif
          else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // gnt wins over both a coincident rvalid and the timeout
        if (mem_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d   = DONE;
          rd_data_d = ld_data;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        rd_data_d  = '0;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      data_q     <= data_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall     = mem_op && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign rd_data   = rd_data_q;
  assign bus_err   = bus_err_q;
  assign misalign  = misalign_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = (state_q == REQ) ? lane_be : 4'b0000;
  assign mem_wdata = lane_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// operations compared against a byte-level reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 8;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in = 1'b0;
  logic [6:0]  opcode_reg = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUResult = '0;
  logic [31:0] store_data = '0;
  logic        stall, done, bus_err, misalign;
  logic [31:0] rd_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .opcode_reg (opcode_reg),
    .funct3     (funct3),
    .ALUResult  (ALUResult),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .rd_data    (rd_data),
    .bus_err    (bus_err),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    bit          bus;
    bit          err;
    bit          mis;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          done_cyc;
  } exp_t;

  // Reference: what the bus and the writeback should see, derived byte by byte.
  function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input int gd, input int rv,
                                 input logic [31:0] rdata);
    exp_t        e;
    int          size;
    int          lane;
    bit          legal;
    bit          odd;
    bit          tmo;
    logic [31:0] ea;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    odd   = (a % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    ea    = a;
    e.bus = legal && !odd;
    e.mis = legal && odd;
`else
    ea    = a - (a % size);
    e.bus = legal;
    e.mis = 1'b0;
`endif
    lane   = int'(ea % 4);
    e.addr = ea & 32'hFFFF_FFFC;
    e.be   = '0;
    for (int k = 0; k < size; k++)
      if (lane + k < 4) e.be[lane + k] = 1'b1;
    for (int i = 0; i < 4; i++)
      e.wd[8*i +: 8] = d[8*(i % size) +: 8];
    v = '0;
    for (int k = 0; k < size; k++)
      if (lane + k < 4) v[8*k +: 8] = rdata[8*(lane + k) +: 8];
    if (!f3[2] && size < 4 && v[8*size - 1])
      for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
    tmo   = e.bus && (st ? (gd >= int'(TO)) : (gd + rv + 2 > int'(TO)));
    e.rd  = (e.bus && !st && !tmo) ? v : 32'h0;
    e.err = !legal || tmo;
    if (!e.bus)   e.done_cyc = 1;
    else if (tmo) e.done_cyc = 1 + int'(TO);
    else if (st)  e.done_cyc = 2 + gd;
    else          e.done_cyc = 3 + gd + rv;
    return e;
  endfunction

  task automatic run_op(input string nm, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rv, input logic [31:0] rdata);
    exp_t e;
    int   cyc;
    int   k;
    int   phase;
    bit   got_done;
    bit   addr_checked;
    e = model(st, f3, a, d, gd, rv, rdata);
    @(negedge clk);
    valid_in   = 1'b1;
    opcode_reg = st ? OPC_STORE : OPC_LOAD;
    funct3     = f3;
    ALUResult  = a;
    store_data = d;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_eq({nm, "_stall_first"}, 32'(stall), 32'd1);
    cyc = 0; k = 0; phase = 0; got_done = 0; addr_checked = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (done) begin
        got_done = 1;
        check_eq({nm, "_done_cyc"}, 32'(cyc), 32'(e.done_cyc));
        check_eq({nm, "_rd_data"}, rd_data, e.rd);
        check_eq({nm, "_bus_err"}, 32'(bus_err), 32'(e.err));
        check_eq({nm, "_misalign"}, 32'(misalign), 32'(e.mis));
        check_eq({nm, "_stall_done"}, 32'(stall), 32'd0);
        valid_in = 1'b0;
      end else begin
        check_eq({nm, "_req"}, 32'(mem_req), 32'(e.bus && phase == 0));
        if (e.bus && phase == 0 && !addr_checked) begin
          addr_checked = 1;
          check_eq({nm, "_addr"}, mem_addr, e.addr);
          check_eq({nm, "_be"}, 32'(mem_be), 32'(e.be));
          check_eq({nm, "_we"}, 32'(mem_we), 32'(st));
          if (st) check_eq({nm, "_wdata"}, mem_wdata, e.wd);
        end
        if (e.bus && phase == 0) begin
          mem_rvalid = 1'($urandom % 2);
          if (k == gd) begin
            mem_gnt = 1'b1;
            phase   = st ? 2 : 1;
            k       = 0;
          end else begin
            k++;
          end
        end else if (phase == 1) begin
          if (k == rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
          end
          k++;
        end
      end
    end
    if (!got_done) check_eq({nm, "_done_seen"}, 32'd0, 32'd1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    valid_in   = 1'b0;
    @(posedge clk);
    #1;
    check_eq({nm, "_done_after"}, 32'(done), 32'd0);
    check_eq({nm, "_req_after"}, 32'(mem_req), 32'd0);
  endtask

  task automatic run_nonmem();
    @(negedge clk);
    valid_in   = 1'b1;
    opcode_reg = OPC_ALU;
    funct3     = 3'($urandom);
    ALUResult  = $urandom;
    #1;
    check_eq("alu_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check_eq("alu_req", 32'(mem_req), 32'd0);
    check_eq("alu_done", 32'(done), 32'd0);
    valid_in = 1'b0;
  endtask

  task automatic check_quiet(input string nm);
    check_eq({nm, "_done"}, 32'(done), 32'd0);
    check_eq({nm, "_req"}, 32'(mem_req), 32'd0);
    check_eq({nm, "_rd"}, rd_data, 32'd0);
    check_eq({nm, "_err"}, 32'(bus_err), 32'd0);
  endtask

  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd", rd_data, 32'd0);
    check_eq("rst_err", 32'(bus_err), 32'd0);
    check_eq("rst_mis", 32'(misalign), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_be", 32'(mem_be), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("sw",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_op("sb",   1'b1, 3'b000, 32'h103, 32'h000000AB, 0, 0, 32'h0);
    run_op("lb",   1'b0, 3'b000, 32'h102, 32'h0, 0, 0, 32'h80FF7F00);
    run_op("lbu",  1'b0, 3'b100, 32'h102, 32'h0, 1, 1, 32'h80FF7F00);
    run_op("lh",   1'b0, 3'b001, 32'h102, 32'h0, 0, 2, 32'h80FF7F00);
    run_op("lh_m", 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h80FF7F00);
    run_op("sw_m", 1'b1, 3'b010, 32'h10E, 32'h12345678, 1, 0, 32'h0);
    run_op("ill_ld", 1'b0, 3'b011, 32'h200, 32'h0, 0, 0, 32'h0);
    run_op("ill_st", 1'b1, 3'b100, 32'h200, 32'h55, 0, 0, 32'h0);
    run_op("to_st", 1'b1, 3'b010, 32'h300, 32'h1, 100, 0, 32'h0);
    run_op("to_ld", 1'b0, 3'b010, 32'h300, 32'h0, 2, 100, 32'hFFFFFFFF);
    run_nonmem();

    // Reset while waiting for load data; later rvalid pulses must be ignored.
    @(negedge clk);
    valid_in = 1'b1; opcode_reg = OPC_LOAD; funct3 = 3'b010; ALUResult = 32'h400;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check_eq("rstw_req_pre", 32'(mem_req), 32'd0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet("rstw_in");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      @(posedge clk); #1;
      check_quiet("rstw_after");
    end
    mem_rvalid = 1'b0;

    // Reset while requesting drops mem_req without waiting for a clock.
    @(negedge clk);
    valid_in = 1'b1; opcode_reg = OPC_STORE; funct3 = 3'b010; ALUResult = 32'h500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rstr_req_pre", 32'(mem_req), 32'd1);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstr_req_in", 32'(mem_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_quiet("rstr_after");

    for (int n = 0; n < 60; n++) begin
      bit          st;
      logic [2:0]  f3;
      int          gd;
      int          rv;
      st = 1'($urandom % 2);
      if ($urandom % 6 == 0) f3 = 3'($urandom);
      else if (st)           f3 = 3'($urandom_range(0, 2));
      else                   f3 = load_f3[$urandom % 5];
      gd = st ? int'($urandom % 5) : int'($urandom % 4);
      rv = int'($urandom % 3);
      if ($urandom % 8 == 0) run_nonmem();
      run_op("rnd", st, f3, $urandom, $urandom, gd, rv, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
